// File: rtl/cpu_types_pkg.sv
// Shared CPU/cache types: word type, RAM handshake state and the coherence
// bus controller state encoding.
package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   // RAM handshake status; only ACCESS completes a word
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   // Coherence bus controller states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WB    = 3'd1,
      SNOOP = 3'd2,
      FWD   = 3'd3,
      MEMRD = 3'd4
   } bus_state_t;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Two-way round-robin arbiter.
//   clk, rst   : clock, asynchronous active-high reset
//   req_i      : request vector (bit i = cache i)
//   accept_i   : grant taken this cycle; advances the priority pointer
//   gnt_o      : one-hot grant (combinational from req_i and pointer)
module bus_rr_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o
);

   logic rr_q, rr_d;

   // Pointer only matters when both request
   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) begin
         gnt_o = rr_q ? 2'b10 : 2'b01;
      end
   end

   // Priority moves to the cache that was not granted
   always_comb begin
      rr_d = rr_q;
      if (accept_i && (gnt_o != 2'b00)) begin
         rr_d = gnt_o[0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// MSI coherence bus controller for two dcaches sharing one RAM port.
// Grants the bus to one requester, snoops the other cache, and moves a block
// either cache-to-cache (with RAM writeback) or from RAM; also serves evictions.
//   CLK, RST                       : clock, asynchronous active-high reset
//   dREN/dWEN/daddr/dstore         : per-cache word request, address, data
//   cctrans/ccwrite                : per-cache coherence handshake inputs
//   dwait/dload                    : per-cache stall and read data
//   ccwait/ccinv/ccsnoopaddr       : per-cache snoop request outputs
//   ramREN/ramWEN/ramaddr/ramstore : RAM request
//   ramload/ramstate               : RAM read data and handshake status
// All outputs decode the registered state with the live inputs.
module coherence_bus_ctrl
   import cpu_types_pkg::*;
#(
   parameter int unsigned CPUS  = 2,
   parameter int unsigned WORDS = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [CPUS-1:0]              dREN,
   input  logic [CPUS-1:0]              dWEN,
   input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
   input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
   input  logic [CPUS-1:0]              cctrans,
   input  logic [CPUS-1:0]              ccwrite,
   output logic [CPUS-1:0]              dwait,
   output logic [CPUS-1:0][WORD_W-1:0]  dload,
   output logic [CPUS-1:0]              ccwait,
   output logic [CPUS-1:0]              ccinv,
   output logic [CPUS-1:0][WORD_W-1:0]  ccsnoopaddr,
   output logic                         ramREN,
   output logic                         ramWEN,
   output logic [WORD_W-1:0]            ramaddr,
   output logic [WORD_W-1:0]            ramstore,
   input  logic [WORD_W-1:0]            ramload,
   input  ramstate_t                    ramstate
);

   localparam int unsigned WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   bus_state_t        state_q, state_d;
   logic              req_q, req_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;

   logic       snp;
   logic [1:0] elig;
   logic [1:0] gnt;
   logic       gidx;
   logic       accept;
   logic       word_done;
   logic       last_word;

   assign snp       = ~req_q;
   // Eviction, or coherent miss; a plain dREN without cctrans is ignored
   assign elig      = (dWEN & ~cctrans) | (dREN & cctrans);
   assign accept    = (state_q == IDLE) && (elig != 2'b00);
   assign gidx      = gnt[1];
   assign word_done = (ramstate == ACCESS);
   assign last_word = (wcnt_q == WCNT_W'(WORDS - 1));

   bus_rr_arbiter u_arb (
      .clk      (CLK),
      .rst      (RST),
      .req_i    (elig),
      .accept_i (accept),
      .gnt_o    (gnt)
   );

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         IDLE: begin
            wcnt_d = '0;
            if (accept) begin
               req_d   = gidx;
               state_d = (dWEN[gidx] && !cctrans[gidx]) ? WB : SNOOP;
            end
         end
         SNOOP: begin
            if (cctrans[snp]) begin
               state_d = ccwrite[snp] ? FWD : MEMRD;
            end
         end
         WB, FWD, MEMRD: begin
            if (word_done) begin
               if (last_word) begin
                  state_d = IDLE;
                  wcnt_d  = '0;
               end else begin
                  wcnt_d = wcnt_q + WCNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      dwait       = '1;
      dload       = '0;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      case (state_q)
         WB: begin
            ramWEN   = 1'b1;
            ramaddr  = daddr[req_q];
            ramstore = dstore[req_q];
            if (word_done) dwait[req_q] = 1'b0;
         end
         SNOOP, FWD, MEMRD: begin
            // Snoop stays asserted until the last block word completes
            ccwait[snp]      = 1'b1;
            ccinv[snp]       = ccwrite[req_q];
            ccsnoopaddr[snp] = daddr[req_q];
            if (state_q == FWD) begin
               // Snooper data goes to the requester and is written back to RAM
               ramWEN        = dWEN[snp];
               ramaddr       = daddr[snp];
               ramstore      = dstore[snp];
               dload[req_q]  = dstore[snp];
               if (word_done) begin
                  dwait[req_q] = 1'b0;
                  dwait[snp]   = 1'b0;
               end
            end else if (state_q == MEMRD) begin
               ramREN       = 1'b1;
               ramaddr      = daddr[req_q];
               dload[req_q] = ramload;
               if (word_done) dwait[req_q] = 1'b0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: table of per-cycle vectors plus
// hand-written sequences for arbitration alternation and mid-transaction reset.
module tb_coherence_bus_ctrl;
   import cpu_types_pkg::*;

   logic             CLK;
   logic             RST;
   logic [1:0]       dREN, dWEN, cctrans, ccwrite;
   logic [1:0][31:0] daddr, dstore;
   logic [1:0]       dwait, ccwait, ccinv;
   logic [1:0][31:0] dload, ccsnoopaddr;
   logic             ramREN, ramWEN;
   logic [31:0]      ramaddr, ramstore, ramload;
   ramstate_t        ramstate;

   int n_chk;
   int n_err;

   coherence_bus_ctrl #(.CPUS(2), .WORDS(2)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .dREN        (dREN),
      .dWEN        (dWEN),
      .daddr       (daddr),
      .dstore      (dstore),
      .cctrans     (cctrans),
      .ccwrite     (ccwrite),
      .dwait       (dwait),
      .dload       (dload),
      .ccwait      (ccwait),
      .ccinv       (ccinv),
      .ccsnoopaddr (ccsnoopaddr),
      .ramREN      (ramREN),
      .ramWEN      (ramWEN),
      .ramaddr     (ramaddr),
      .ramstore    (ramstore),
      .ramload     (ramload),
      .ramstate    (ramstate)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0]  ren, wen, trans, wr;
      logic [31:0] a0, a1, s0, s1, rload;
      ramstate_t   rs;
      logic [1:0]  e_dwait, e_ccwait, e_ccinv;
      logic        e_ren, e_wen;
      logic [31:0] e_raddr, e_rstore, e_dl0, e_dl1, e_sa0, e_sa1;
   } vec_t;

   localparam int NV = 20;
   localparam logic [31:0] Z = 32'h0;
   vec_t vt [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic zero_inputs();
      dREN = 2'b00; dWEN = 2'b00; cctrans = 2'b00; ccwrite = 2'b00;
      daddr = '0; dstore = '0; ramload = 32'h0; ramstate = FREE;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      zero_inputs();
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   task automatic drive(input vec_t v);
      dREN = v.ren; dWEN = v.wen; cctrans = v.trans; ccwrite = v.wr;
      daddr[0] = v.a0; daddr[1] = v.a1; dstore[0] = v.s0; dstore[1] = v.s1;
      ramload = v.rload; ramstate = v.rs;
   endtask

   task automatic check_vec(input int k, input vec_t v);
      string p;
      p = $sformatf("v%0d", k);
      chk({p, ".dwait"},  32'(dwait),  32'(v.e_dwait));
      chk({p, ".ccwait"}, 32'(ccwait), 32'(v.e_ccwait));
      chk({p, ".ccinv"},  32'(ccinv),  32'(v.e_ccinv));
      chk({p, ".ramREN"}, 32'(ramREN), 32'(v.e_ren));
      chk({p, ".ramWEN"}, 32'(ramWEN), 32'(v.e_wen));
      chk({p, ".ramaddr"},  ramaddr,  v.e_raddr);
      chk({p, ".ramstore"}, ramstore, v.e_rstore);
      chk({p, ".dload0"}, dload[0], v.e_dl0);
      chk({p, ".dload1"}, dload[1], v.e_dl1);
      chk({p, ".snpaddr0"}, ccsnoopaddr[0], v.e_sa0);
      chk({p, ".snpaddr1"}, ccsnoopaddr[1], v.e_sa1);
   endtask

   logic        r;
   logic [1:0]  e_cw, e_dw;
   logic [31:0] e_addr;

   initial begin
      n_chk = 0;
      n_err = 0;

      // Cache0 coherent read miss at 0x100, cache1 snoop misses -> MEMRD
      vt[0]  = '{2'b01,2'b00,2'b01,2'b00, 32'h100,Z,Z,Z,Z,FREE,
                 2'b11,2'b00,2'b00,1'b0,1'b0, Z,Z,Z,Z,Z,Z};
      vt[1]  = '{2'b01,2'b00,2'b11,2'b00, 32'h100,Z,Z,Z,Z,FREE,
                 2'b11,2'b10,2'b00,1'b0,1'b0, Z,Z,Z,Z,Z,32'h100};
      vt[2]  = '{2'b01,2'b00,2'b01,2'b00, 32'h100,Z,Z,Z,32'h5555,BUSY,
                 2'b11,2'b10,2'b00,1'b1,1'b0, 32'h100,Z,32'h5555,Z,Z,32'h100};
      vt[3]  = '{2'b01,2'b00,2'b01,2'b00, 32'h100,Z,Z,Z,32'h11111111,ACCESS,
                 2'b10,2'b10,2'b00,1'b1,1'b0, 32'h100,Z,32'h11111111,Z,Z,32'h100};
      vt[4]  = '{2'b01,2'b00,2'b01,2'b00, 32'h104,Z,Z,Z,32'h22222222,ACCESS,
                 2'b10,2'b10,2'b00,1'b1,1'b0, 32'h104,Z,32'h22222222,Z,Z,32'h104};
      vt[5]  = '{2'b00,2'b00,2'b00,2'b00, Z,Z,Z,Z,Z,FREE,
                 2'b11,2'b00,2'b00,1'b0,1'b0, Z,Z,Z,Z,Z,Z};
      // Cache1 BusRdX at 0x200, cache0 supplies M data -> FWD
      vt[6]  = '{2'b10,2'b00,2'b10,2'b10, Z,32'h200,Z,Z,Z,FREE,
                 2'b11,2'b00,2'b00,1'b0,1'b0, Z,Z,Z,Z,Z,Z};
      vt[7]  = '{2'b10,2'b00,2'b11,2'b11, Z,32'h200,Z,Z,Z,FREE,
                 2'b11,2'b01,2'b01,1'b0,1'b0, Z,Z,Z,Z,32'h200,Z};
      vt[8]  = '{2'b10,2'b01,2'b10,2'b10, 32'h200,32'h200,32'hDEADBEEF,Z,Z,BUSY,
                 2'b11,2'b01,2'b01,1'b0,1'b1, 32'h200,32'hDEADBEEF,Z,32'hDEADBEEF,32'h200,Z};
      vt[9]  = '{2'b10,2'b01,2'b10,2'b10, 32'h200,32'h200,32'hDEADBEEF,Z,Z,ACCESS,
                 2'b00,2'b01,2'b01,1'b0,1'b1, 32'h200,32'hDEADBEEF,Z,32'hDEADBEEF,32'h200,Z};
      vt[10] = '{2'b10,2'b01,2'b10,2'b10, 32'h204,32'h204,32'hCAFEF00D,Z,Z,ACCESS,
                 2'b00,2'b01,2'b01,1'b0,1'b1, 32'h204,32'hCAFEF00D,Z,32'hCAFEF00D,32'h204,Z};
      vt[11] = '{2'b00,2'b00,2'b00,2'b00, Z,Z,Z,Z,Z,FREE,
                 2'b11,2'b00,2'b00,1'b0,1'b0, Z,Z,Z,Z,Z,Z};
      // Cache0 eviction at 0x300, RAM stalls (BUSY x3, ERROR) before ACCESS
      vt[12] = '{2'b00,2'b01,2'b00,2'b00, 32'h300,Z,32'hAAAA0000,Z,Z,FREE,
                 2'b11,2'b00,2'b00,1'b0,1'b0, Z,Z,Z,Z,Z,Z};
      vt[13] = '{2'b00,2'b01,2'b00,2'b00, 32'h300,Z,32'hAAAA0000,Z,Z,BUSY,
                 2'b11,2'b00,2'b00,1'b0,1'b1, 32'h300,32'hAAAA0000,Z,Z,Z,Z};
      vt[14] = vt[13];
      vt[15] = vt[13];
      vt[16] = '{2'b00,2'b01,2'b00,2'b00, 32'h300,Z,32'hAAAA0000,Z,Z,ERROR,
                 2'b11,2'b00,2'b00,1'b0,1'b1, 32'h300,32'hAAAA0000,Z,Z,Z,Z};
      vt[17] = '{2'b00,2'b01,2'b00,2'b00, 32'h300,Z,32'hAAAA0000,Z,Z,ACCESS,
                 2'b10,2'b00,2'b00,1'b0,1'b1, 32'h300,32'hAAAA0000,Z,Z,Z,Z};
      vt[18] = '{2'b00,2'b01,2'b00,2'b00, 32'h304,Z,32'hAAAA0004,Z,Z,ACCESS,
                 2'b10,2'b00,2'b00,1'b0,1'b1, 32'h304,32'hAAAA0004,Z,Z,Z,Z};
      vt[19] = '{2'b00,2'b00,2'b00,2'b00, Z,Z,Z,Z,Z,FREE,
                 2'b11,2'b00,2'b00,1'b0,1'b0, Z,Z,Z,Z,Z,Z};

      // Reset values while RST is held
      RST = 1'b1;
      zero_inputs();
      @(posedge CLK);
      @(negedge CLK);
      chk("rst.dwait",  32'(dwait),  32'h3);
      chk("rst.ccwait", 32'(ccwait), 32'h0);
      chk("rst.ccinv",  32'(ccinv),  32'h0);
      chk("rst.ramREN", 32'(ramREN), 32'h0);
      chk("rst.ramWEN", 32'(ramWEN), 32'h0);
      chk("rst.ramaddr",  ramaddr,  32'h0);
      chk("rst.ramstore", ramstore, 32'h0);
      @(posedge CLK);
      #1;
      RST = 1'b0;

      for (int k = 0; k < NV; k++) begin
         drive(vt[k]);
         @(negedge CLK);
         check_vec(k, vt[k]);
         @(posedge CLK);
         #1;
      end

      // Both caches keep requesting: service order 0,1,0; pending cache is
      // snooped but not granted until the bus returns to IDLE
      do_reset();
      dREN = 2'b11; cctrans = 2'b11; ccwrite = 2'b00;
      daddr[0] = 32'h400; daddr[1] = 32'h500;
      ramstate = ACCESS; ramload = 32'h77;
      for (int t = 0; t < 3; t++) begin
         r = (t == 1);
         for (int c = 0; c < 4; c++) begin
            e_cw   = (c == 0) ? 2'b00 : (r ? 2'b01 : 2'b10);
            e_dw   = (c >= 2) ? (r ? 2'b01 : 2'b10) : 2'b11;
            e_addr = (c >= 2) ? (r ? 32'h500 : 32'h400) : 32'h0;
            @(negedge CLK);
            chk($sformatf("rr%0d.%0d.ccwait", t, c), 32'(ccwait), 32'(e_cw));
            chk($sformatf("rr%0d.%0d.dwait", t, c),  32'(dwait),  32'(e_dw));
            chk($sformatf("rr%0d.%0d.ramaddr", t, c), ramaddr, e_addr);
            chk($sformatf("rr%0d.%0d.ramREN", t, c), 32'(ramREN), 32'(c >= 2));
            chk($sformatf("rr%0d.%0d.ram_excl", t, c), 32'(ramREN & ramWEN), 32'h0);
            @(posedge CLK);
            #1;
         end
      end

      // Reset asserted in FWD after word 0
      do_reset();
      dREN = 2'b10; cctrans = 2'b11; ccwrite = 2'b11; daddr[1] = 32'h600;
      @(negedge CLK);
      chk("mr.idle.ccwait", 32'(ccwait), 32'h0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("mr.snoop.ccwait", 32'(ccwait), 32'h1);
      @(posedge CLK); #1;
      dWEN = 2'b01; daddr[0] = 32'h600; dstore[0] = 32'h12345678; ramstate = ACCESS;
      @(negedge CLK);
      chk("mr.w0.dwait", 32'(dwait), 32'h0);
      chk("mr.w0.dload1", dload[1], 32'h12345678);
      chk("mr.w0.ramWEN", 32'(ramWEN), 32'h1);
      @(posedge CLK); #1;
      chk("mr.w1.ccwait", 32'(ccwait), 32'h1);
      RST = 1'b1;
      #1;
      chk("mr.rst.ccwait", 32'(ccwait), 32'h0);
      chk("mr.rst.dwait",  32'(dwait),  32'h3);
      chk("mr.rst.ccinv",  32'(ccinv),  32'h0);
      chk("mr.rst.ramWEN", 32'(ramWEN), 32'h0);
      chk("mr.rst.ramREN", 32'(ramREN), 32'h0);
      chk("mr.rst.ramaddr",  ramaddr,  32'h0);
      chk("mr.rst.ramstore", ramstore, 32'h0);
      chk("mr.rst.dload1", dload[1], 32'h0);
      @(posedge CLK); #1;
      RST = 1'b0;
      dWEN = 2'b00; cctrans = 2'b10; ccwrite = 2'b10; ramstate = FREE;
      @(negedge CLK);
      chk("mr2.idle.ccwait", 32'(ccwait), 32'h0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("mr2.snoop.ccwait", 32'(ccwait), 32'h1);
      chk("mr2.snoop.ramWEN", 32'(ramWEN), 32'h0);
      @(posedge CLK); #1;
      cctrans = 2'b11; ccwrite = 2'b11; dWEN = 2'b01;
      daddr[0] = 32'h600; dstore[0] = 32'hA0; ramstate = ACCESS;
      @(negedge CLK);
      chk("mr2.snoop2.ccwait", 32'(ccwait), 32'h1);
      chk("mr2.snoop2.dwait",  32'(dwait),  32'h3);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("mr2.w0.dwait", 32'(dwait), 32'h0);
      chk("mr2.w0.ramaddr", ramaddr, 32'h600);
      @(posedge CLK); #1;
      daddr[0] = 32'h604; dstore[0] = 32'hA4;
      @(negedge CLK);
      chk("mr2.w1.dwait", 32'(dwait), 32'h0);
      chk("mr2.w1.ramaddr", ramaddr, 32'h604);
      chk("mr2.w1.dload1", dload[1], 32'hA4);
      @(posedge CLK); #1;
      zero_inputs();
      @(negedge CLK);
      chk("mr2.end.ccwait", 32'(ccwait), 32'h0);
      chk("mr2.end.dwait",  32'(dwait),  32'h3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/coherence_bus_ctrl.md
# coherence_bus_ctrl

Coherence bus controller for the two-core MSI data-cache system. It sits between the per-core dcaches (requester side and snoop side) and the single RAM request port. It decides which dcache owns the bus and drives `ccwait`/`ccinv`/`ccsnoopaddr` into the other core's snoop unit. It then routes each block word either cache-to-cache, with a simultaneous RAM writeback, or from RAM.

## Interface
Parameters:
- `CPUS`, 2 — number of dcaches; only 2 is supported.
- `WORDS`, 2 — words per dcache block; one coherent transaction moves exactly `WORDS` words.

Ports (index `i` = cache number; reset is asynchronous and active-high):
- `CLK`  in  1  — clock, rising edge.
- `RST`  in  1  — asynchronous, active-high reset.
- `dREN`  in  [CPUS]  — word read request.
- `dWEN`  in  [CPUS]  — word write request; this is either an eviction, or snoop data when this cache is the snooper.
- `daddr`  in  [CPUS] x 32  — word address.
- `dstore`  in  [CPUS] x 32  — write data.
- `cctrans`  in  [CPUS]  — requester: coherent miss in progress; snooper: snoop lookup done.
- `ccwrite`  in  [CPUS]  — requester: BusRdX; snooper: block is M and the snooper will supply it.
- `dwait`  out  [CPUS]  — stall; low for exactly the cycle a word completes.
- `dload`  out  [CPUS] x 32  — read data.
- `ccwait`  out  [CPUS]  — snoop request to that cache.
- `ccinv`  out  [CPUS]  — invalidate-on-snoop.
- `ccsnoopaddr`  out  [CPUS] x 32  — address to snoop.
- `ramREN`, `ramWEN`  out  1 each  — RAM request.
- `ramaddr`, `ramstore`  out  32 each  — RAM address and data.
- `ramload`  in  32  — RAM read data.
- `ramstate`  in  `ramstate_t`  — FREE / BUSY / ACCESS / ERROR.

## Operation
- States: IDLE, WB, SNOOP, FWD, MEMRD.
- Word counter `wcnt` counts 0..WORDS-1 and clears on every entry to IDLE.
- Registers `req` (requester), `snp` (other cache) and `rr` (round-robin priority) are kept.

IDLE:
- Cache `i` is eligible when (`dWEN[i]` & !`cctrans[i]`) or (`dREN[i]` & `cctrans[i]`).
- If both caches are eligible, the grant goes to `rr`. The grant then sets `rr` to the other cache.
- Eviction → WB. Coherent miss → SNOOP.
- Non-coherent `dREN` (no `cctrans`) is illegal and is ignored.
- An S→M upgrade is always issued as BusRdX: `dREN` + `cctrans` + `ccwrite`.

WB:
- Drive `ramWEN`=1, `ramaddr`=`daddr[req]`, `ramstore`=`dstore[req]`.
- On `ramstate`==ACCESS: `dwait[req]`=0 and `wcnt`++.
- After `WORDS` completions → IDLE.

SNOOP:
- Drive `ccwait[snp]`=1, `ccsnoopaddr[snp]`=`daddr[req]`, `ccinv[snp]`=`ccwrite[req]`.
- Wait for `cctrans[snp]`. When it arrives: `ccwrite[snp]` → FWD, else MEMRD.

FWD:
- `ccwait[snp]` stays 1.
- Snooper drives `dWEN`/`daddr`/`dstore`; the controller mirrors these to `ramWEN`/`ramaddr`/`ramstore`.
- `dload[req]`=`dstore[snp]`.
- On ACCESS: `dwait[req]`=`dwait[snp]`=0 and `wcnt`++.
- After `WORDS` words → IDLE.

MEMRD:
- Drive `ramREN`=1, `ramaddr`=`daddr[req]`, `dload[req]`=`ramload`.
- On ACCESS: `dwait[req]`=0 and `wcnt`++.
- After `WORDS` words → IDLE.

Rules that apply in all states:
- A cache under `ccwait` is never granted. Its own pending request waits until IDLE.
- `ramstate` ERROR, BUSY or FREE all count as not done; the controller holds its request and does not time out.
- `ramREN` and `ramWEN` are never both 1.
- Outputs for a non-selected cache: `dwait`=1, `ccwait`=0, `ccinv`=0, `dload`=0, `ccsnoopaddr`=0.

## Timing
- Reset values: state IDLE, `rr`=0, `wcnt`=0, `dwait`=all 1, `ccwait`=0, `ccinv`=0, `ccsnoopaddr`=0, `dload`=0, `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0.
- If `RST` is asserted mid-transaction, all of these apply immediately, including `ccwait` dropping.
- Outputs are combinational decodes of the registered state and the live inputs.
- The grant is registered, so a request seen in IDLE at edge n puts the block in SNOOP or WB during cycle n+1.
- `ccwait` is high from the first SNOOP cycle through the last FWD/MEMRD word, inclusive.
- `dwait` low is a single cycle, coincident with ACCESS. The next word may complete no earlier than the following cycle.
- Minimum coherent miss: 1 grant cycle + 1 SNOOP cycle (if `cctrans[snp]` is already high) + `WORDS` ACCESS cycles.
- Simultaneous eligibility: decided only by `rr`. `rr` advances only on a grant, never on completion.

## Structure
- Add `bus_state_t` (IDLE, WB, SNOOP, FWD, MEMRD) to `cpu_types_pkg`.
- `ramstate_t` and `word_t` come from `cpu_types_pkg`.
- Sub-module `bus_rr_arbiter`: 2-way round-robin, with request vector in, one-hot grant out, and a pointer update on accept.

## Test plan
- Cache0 coherent read miss at 0x100, cache1 snoop misses (`cctrans`=1, `ccwrite`=0) → MEMRD. `ramREN` at 0x100 then 0x104. `dwait[0]` pulses twice. `ccinv[1]`=0.
- Cache1 BusRdX at 0x200, cache0 holds M (`ccwrite`=1, supplies 0xDEADBEEF, 0xCAFEF00D) → `dload[1]` matches. `ramWEN` writes both words. `ccinv[0]`=1 throughout.
- Both caches request in the same cycle, after reset → cache0 served first, then cache1. A repeated double request alternates service (`rr` toggles).
- Cache0 eviction (`dWEN`, no `cctrans`) at 0x300 with `ramstate` BUSY for 3 cycles, then ACCESS → `dwait[0]` low only on the ACCESS cycles. `ccwait` never asserted.
- Cache1 snooped (`ccwait[1]`=1) while its own `dREN`+`cctrans` is pending → cache1 not granted until cache0's transaction ends, then granted on the next IDLE.
- `RST` asserted during FWD after word 0 → `ccwait`=0, `dwait`=all 1, RAM signals 0 in the same cycle. A fresh request after release starts from SNOOP with `wcnt`=0.
